// File: rtl/act_seq_pkg.sv
// Shared types and defaults for the activation-unit instruction sequencer.
package act_seq_pkg;
  localparam int NUM_INST_DEF = 16;
  localparam int NUM_REG_DEF  = 4;
  localparam int VEC_W_DEF    = 8;
  localparam int REG_W        = $clog2(NUM_REG_DEF);

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_LOAD  = 4'd1,
    OP_STORE = 4'd2,
    OP_ONEX  = 4'd3,
    OP_TANH  = 4'd4,
    OP_EMUL  = 4'd5,
    OP_COPY  = 4'd6
  } op_e;

  typedef struct packed {
    logic [3:0]       op;
    logic [REG_W-1:0] dst;
    logic [REG_W-1:0] src;
  } inst_t;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_DONE} state_e;

  function automatic logic is_rsvd(input logic [3:0] op);
    return op > OP_COPY;
  endfunction
endpackage

// File: rtl/act_inst_mem.sv
// Instruction list: flop array, one write port, registered read that
// substitutes NOP for reserved opcodes and flags them.
module act_inst_mem
  import act_seq_pkg::*;
#(
  parameter int DEPTH = NUM_INST_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  inst_t         wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output inst_t         rd_data_o,
  output logic          rd_ill_o
);
  inst_t mem_q [DEPTH];
  inst_t rd_q;
  logic  ill_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q  <= '0;
      ill_q <= 1'b0;
    end else if (rd_en_i) begin
      rd_q  <= is_rsvd(mem_q[rd_addr_i].op) ? '0 : mem_q[rd_addr_i];
      ill_q <= is_rsvd(mem_q[rd_addr_i].op);
    end
  end

  assign rd_data_o = rd_q;
  assign rd_ill_o  = ill_q;
endmodule

// File: rtl/act_inst_sequencer.sv
// Replays the programmed instruction list once per vector, one op per
// val/rdy handshake, then signals done.
module act_inst_sequencer
  import act_seq_pkg::*;
#(
  parameter int NUM_INST = NUM_INST_DEF,
  parameter int NUM_REG  = NUM_REG_DEF,
  parameter int VEC_W    = VEC_W_DEF,
  localparam int PC_W    = $clog2(NUM_INST),
  localparam int RW      = $clog2(NUM_REG),
  localparam int NI_W    = PC_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_wr_val,
  output logic             cfg_wr_rdy,
  input  logic [PC_W-1:0]  cfg_wr_addr,
  input  logic [7:0]       cfg_wr_data,
  input  logic [NI_W-1:0]  cfg_num_inst,
  input  logic [VEC_W-1:0] cfg_num_vec,
  input  logic             start_val,
  output logic             start_rdy,
  output logic             op_val,
  input  logic             op_rdy,
  output logic [3:0]       op_code,
  output logic [RW-1:0]    op_dst,
  output logic [RW-1:0]    op_src,
  output logic             op_last,
  output logic             done_val,
  input  logic             done_rdy,
  output logic             busy,
  output logic             err_illegal
);
  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [NI_W-1:0]  ni_q, ni_d, ni_sat;
  logic [VEC_W-1:0] nv_q, nv_d;
  logic             err_q, err_d;
  logic             rd_en, rd_ill, last_inst, last_vec, idle;
  inst_t            rd_inst;

  assign idle   = (state_q == S_IDLE);
  assign ni_sat = (cfg_num_inst > NI_W'(NUM_INST)) ? NI_W'(NUM_INST) : cfg_num_inst;

  act_inst_mem #(.DEPTH(NUM_INST)) u_mem (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (cfg_wr_val & idle),
    .wr_addr_i (cfg_wr_addr),
    .wr_data_i (inst_t'(cfg_wr_data)),
    .rd_en_i   (rd_en),
    .rd_addr_i (pc_q),
    .rd_data_o (rd_inst),
    .rd_ill_o  (rd_ill)
  );

  // Counts are compared against latched copies so mid-run config edits are inert.
  assign last_inst = ({1'b0, pc_q} == ni_q - NI_W'(1));
  assign last_vec  = (vec_q == nv_q - VEC_W'(1));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    vec_d   = vec_q;
    ni_d    = ni_q;
    nv_d    = nv_q;
    err_d   = err_q;
    rd_en   = 1'b0;
    case (state_q)
      S_IDLE: if (start_val) begin
        ni_d    = ni_sat;
        nv_d    = cfg_num_vec;
        err_d   = 1'b0;
        pc_d    = '0;
        vec_d   = '0;
        state_d = (ni_sat == '0 || cfg_num_vec == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        rd_en   = 1'b1;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (rd_ill) err_d = 1'b1;
        if (op_rdy) begin
          if (last_inst && last_vec) begin
            state_d = S_DONE;
          end else if (last_inst) begin
            pc_d    = '0;
            vec_d   = vec_q + VEC_W'(1);
            state_d = S_FETCH;
          end else begin
            pc_d    = pc_q + PC_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: if (done_rdy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      vec_q   <= '0;
      ni_q    <= '0;
      nv_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      vec_q   <= vec_d;
      ni_q    <= ni_d;
      nv_q    <= nv_d;
      err_q   <= err_d;
    end
  end

  assign cfg_wr_rdy  = idle;
  assign start_rdy   = idle;
  assign busy        = !idle;
  assign op_val      = (state_q == S_ISSUE);
  assign op_code     = rd_inst.op;
  assign op_dst      = rd_inst.dst;
  assign op_src      = rd_inst.src;
  assign op_last     = op_val && last_inst && last_vec;
  assign done_val    = (state_q == S_DONE);
  assign err_illegal = err_q;
endmodule

// File: tb/tb_act_inst_sequencer.sv
// Directed bench for act_inst_sequencer: reset, replay order, backpressure,
// zero counts, illegal opcodes, config lockout.
module tb_act_inst_sequencer;
  logic       clk = 0;
  logic       rst = 0;
  logic       cfg_wr_val = 0, cfg_wr_rdy;
  logic [3:0] cfg_wr_addr = 0;
  logic [7:0] cfg_wr_data = 0;
  logic [4:0] cfg_num_inst = 0;
  logic [7:0] cfg_num_vec = 0;
  logic       start_val = 0, start_rdy;
  logic       op_val, op_rdy = 0, op_last;
  logic [3:0] op_code;
  logic [1:0] op_dst, op_src;
  logic       done_val, done_rdy = 0, busy, err_illegal;

  int checks = 0, errors = 0;
  logic [7:0] op_log[$];
  logic       last_log[$];
  logic [7:0] held;
  int first_cyc, done_cyc, done_held, stall_ok, wr_rdy_bad;

  always #5 clk = ~clk;

  act_inst_sequencer dut (
    .clk(clk), .rst(rst),
    .cfg_wr_val(cfg_wr_val), .cfg_wr_rdy(cfg_wr_rdy), .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_data(cfg_wr_data), .cfg_num_inst(cfg_num_inst), .cfg_num_vec(cfg_num_vec),
    .start_val(start_val), .start_rdy(start_rdy),
    .op_val(op_val), .op_rdy(op_rdy), .op_code(op_code), .op_dst(op_dst), .op_src(op_src),
    .op_last(op_last), .done_val(done_val), .done_rdy(done_rdy), .busy(busy),
    .err_illegal(err_illegal)
  );

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    cfg_wr_val = 1; cfg_wr_addr = a; cfg_wr_data = d;
    @(posedge clk); #1;
    cfg_wr_val = 0;
  endtask

  task automatic prog_std();
    wr(0, 8'h10); wr(1, 8'h34); wr(2, 8'h49); wr(3, 8'h22);
  endtask

  // Starts a run and logs every accepted op; cycle 1 is the cycle after start accept.
  task automatic run(input int ni, input int nv, input int stall_idx, input int stall_n,
                     input int done_hold, input logic mid_wr);
    int cyc, stalled;
    op_log.delete(); last_log.delete();
    first_cyc = -1; done_cyc = -1; done_held = 0; stall_ok = 1; wr_rdy_bad = 0;
    cfg_num_inst = 5'(ni); cfg_num_vec = 8'(nv);
    op_rdy = 0; done_rdy = 0; start_val = 1;
    @(posedge clk); #1;
    start_val = 0; cfg_wr_val = mid_wr;
    if (mid_wr) begin cfg_wr_addr = 0; cfg_wr_data = 8'h66; end
    cyc = 1; stalled = 0;
    while (cyc < 1000 && !done_val) begin
      if (cfg_wr_rdy) wr_rdy_bad = 1;
      if (op_val) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (op_log.size() == stall_idx && stalled < stall_n) begin
          if (stalled == 0) held = {op_code, op_dst, op_src};
          else if ({op_code, op_dst, op_src} !== held) stall_ok = 0;
          op_rdy = 0; stalled++;
        end else begin
          if (stall_n > 0 && op_log.size() == stall_idx && {op_code, op_dst, op_src} !== held)
            stall_ok = 0;
          op_rdy = 1;
          op_log.push_back({op_code, op_dst, op_src});
          last_log.push_back(op_last);
        end
      end else op_rdy = 0;
      @(posedge clk); #1; cyc++;
    end
    op_rdy = 0; cfg_wr_val = 0;
    if (done_val) begin
      done_cyc = cyc;
      repeat (done_hold) begin @(posedge clk); #1; if (done_val) done_held++; end
      done_rdy = 1;
      @(posedge clk); #1;
      done_rdy = 0;
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++; if ({cfg_wr_rdy, start_rdy, op_val, done_val, busy, err_illegal, op_last} !== 7'b1100000) begin
      errors++; $display("FAIL reset_outputs got %b want 1100000",
        {cfg_wr_rdy, start_rdy, op_val, done_val, busy, err_illegal, op_last});
    end
    rst = 1;
    @(posedge clk); #1;
    wr(0, 8'h10);
    cfg_num_inst = 1; cfg_num_vec = 1; start_val = 1;
    @(posedge clk); #1; start_val = 0;
    @(posedge clk); #1;
    checks++; if (op_val !== 1'b1) begin errors++; $display("FAIL reset_pre_issue op_val=%b want 1", op_val); end
    rst = 0; #1;
    checks++; if ({op_val, busy, start_rdy} !== 3'b001) begin
      errors++; $display("FAIL reset_mid_issue {op_val,busy,start_rdy}=%b want 001", {op_val, busy, start_rdy});
    end
    @(posedge clk); #1; rst = 1;
    run(4, 1, -1, 0, 0, 0);
    checks++; if (op_log.size() != 4) begin errors++; $display("FAIL reset_readback count=%0d want 4", op_log.size()); end
    foreach (op_log[i]) begin
      checks++; if (op_log[i] !== 8'h00) begin errors++; $display("FAIL reset_readback[%0d] got %h want 00", i, op_log[i]); end
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp[4] = '{8'h10, 8'h34, 8'h49, 8'h22};
    int nlast;
    prog_std();
    run(4, 3, -1, 0, 0, 0);
    checks++; if (op_log.size() != 12) begin errors++; $display("FAIL basic_count got %0d want 12", op_log.size()); end
    nlast = 0;
    foreach (op_log[i]) begin
      checks++; if (op_log[i] !== exp[i%4]) begin errors++; $display("FAIL basic_op[%0d] got %h want %h", i, op_log[i], exp[i%4]); end
      if (last_log[i]) nlast++;
    end
    checks++; if (nlast != 1 || last_log.size() != 12 || last_log[11] !== 1'b1) begin
      errors++; $display("FAIL basic_last count=%0d want 1 on op 12", nlast);
    end
    checks++; if (first_cyc != 2) begin errors++; $display("FAIL basic_first_op cycle=%0d want 2", first_cyc); end
    checks++; if (done_cyc != 25) begin errors++; $display("FAIL basic_done cycle=%0d want 25", done_cyc); end
    checks++; if (busy !== 1'b0 || start_rdy !== 1'b1) begin
      errors++; $display("FAIL basic_idle busy=%b start_rdy=%b want 0 1", busy, start_rdy);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp[4] = '{8'h10, 8'h34, 8'h49, 8'h22};
    run(4, 1, 1, 5, 0, 0);
    checks++; if (op_log.size() != 4) begin errors++; $display("FAIL bp_count got %0d want 4", op_log.size()); end
    foreach (op_log[i]) begin
      checks++; if (op_log[i] !== exp[i]) begin errors++; $display("FAIL bp_op[%0d] got %h want %h", i, op_log[i], exp[i]); end
    end
    checks++; if (stall_ok != 1) begin errors++; $display("FAIL bp_stable fields changed while stalled, want stable"); end
    checks++; if (done_cyc != 14) begin errors++; $display("FAIL bp_done cycle=%0d want 14", done_cyc); end
  endtask

  task automatic test_zero();
    run(4, 0, -1, 0, 3, 0);
    checks++; if (op_log.size() != 0) begin errors++; $display("FAIL zero_vec ops=%0d want 0", op_log.size()); end
    checks++; if (done_cyc != 1) begin errors++; $display("FAIL zero_vec done cycle=%0d want 1", done_cyc); end
    checks++; if (done_held != 3) begin errors++; $display("FAIL zero_vec done_hold=%0d want 3", done_held); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_vec busy=%b want 0", busy); end
    run(0, 2, -1, 0, 0, 0);
    checks++; if (op_log.size() != 0) begin errors++; $display("FAIL zero_inst ops=%0d want 0", op_log.size()); end
    checks++; if (done_cyc != 1) begin errors++; $display("FAIL zero_inst done cycle=%0d want 1", done_cyc); end
    run(20, 1, -1, 0, 0, 0);
    checks++; if (op_log.size() != 16) begin errors++; $display("FAIL sat_count ops=%0d want 16", op_log.size()); end
    checks++; if (last_log.size() != 16 || last_log[15] !== 1'b1 || last_log[14] !== 1'b0) begin
      errors++; $display("FAIL sat_last op_last not only on op 16, want op 16");
    end
  endtask

  task automatic test_illegal();
    logic [7:0] exp[4] = '{8'h10, 8'h00, 8'h49, 8'h22};
    wr(1, 8'hF0);
    run(4, 1, -1, 0, 0, 0);
    checks++; if (op_log.size() != 4) begin errors++; $display("FAIL ill_count got %0d want 4", op_log.size()); end
    foreach (op_log[i]) begin
      checks++; if (op_log[i] !== exp[i]) begin errors++; $display("FAIL ill_op[%0d] got %h want %h", i, op_log[i], exp[i]); end
    end
    checks++; if (err_illegal !== 1'b1) begin errors++; $display("FAIL ill_flag got %b want 1", err_illegal); end
    wr(1, 8'h34);
    cfg_num_inst = 4; cfg_num_vec = 1; start_val = 1;
    @(posedge clk); #1; start_val = 0;
    checks++; if (err_illegal !== 1'b0) begin errors++; $display("FAIL ill_clear got %b want 0", err_illegal); end
    op_rdy = 1; done_rdy = 1;
    for (int i = 0; i < 20 && busy; i++) begin @(posedge clk); #1; end
    op_rdy = 0; done_rdy = 0;
    checks++; if (busy !== 1'b0 || err_illegal !== 1'b0) begin
      errors++; $display("FAIL ill_clean_run busy=%b err=%b want 0 0", busy, err_illegal);
    end
  endtask

  task automatic test_cfg_lock();
    run(1, 1, -1, 0, 0, 1);
    checks++; if (wr_rdy_bad != 0) begin errors++; $display("FAIL lock_rdy cfg_wr_rdy=1 during run, want 0"); end
    checks++; if (op_log.size() != 1 || op_log[0] !== 8'h10) begin
      errors++; $display("FAIL lock_op0 got %h want 10", op_log.size() ? op_log[0] : 8'hxx);
    end
    run(1, 1, -1, 0, 0, 0);
    checks++; if (op_log.size() != 1 || op_log[0] !== 8'h10) begin
      errors++; $display("FAIL lock_unchanged got %h want 10", op_log.size() ? op_log[0] : 8'hxx);
    end
    cfg_wr_val = 1; cfg_wr_addr = 0; cfg_wr_data = 8'h5B;
    run(2, 1, -1, 0, 0, 0);
    checks++; if (op_log.size() != 2 || op_log[0] !== 8'h5B || op_log[1] !== 8'h34) begin
      errors++; $display("FAIL same_cycle_wr got %h want 5b then 34", op_log.size() ? op_log[0] : 8'hxx);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero();
    test_illegal();
    test_cfg_lock();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
